mc_channel_select: RTL and testbench
====================================

# mc_channel_select

Parametrised successor of the TS QoS main control: selects one of `N_CH` transport-stream inputs for the output mux using per-channel signal presence, per-channel error counts, a programmable priority list, an error threshold and an anti-flap holdoff timer. Sits between the per-channel TS error counters and the output mux, and exposes configuration and status through the same single-cycle memory-mapped port. Adds manual override, threshold-based fault detection and an explicit selection FSM, all scaled by parameters.

## Interface
- `N_CH`, 4: channel count, 2..8
- `CH_W`, `$clog2(N_CH)`: channel index width
- `ERR_W`, 8: per-channel error count width, ≤32
- `TIMER_W`, 20: holdoff timer width, ≤32
- `HOLD_DEFAULT`, 30: holdoff reload value after reset
- `clk` in 1: system clock
- `rst` in 1: asynchronous, active-low reset
- `valid` in `N_CH`: signal presence; bit i = channel i
- `err_count` in `N_CH*ERR_W`: channel i at `[i*ERR_W +: ERR_W]`
- `mm_write_en` in 1: register write strobe
- `mm_read_en` in 1: register read strobe
- `mm_addr` in 8: word address
- `mm_wdata` in 32: write data
- `mm_rdata` out 32: read data, registered
- `mux_control` out `CH_W`: selected channel
- `en_mux` out 1: output mux enable
- `timer` out `TIMER_W`: remaining holdoff cycles

## Operation
- Registers:
  - 0x00 CTRL: [0] fallback_en (rst 1), [1] manual_en (rst 0), [2 +: CH_W] manual_ch (rst 0).
  - 0x01 PRIO: rank r channel at `[r*CH_W +: CH_W]`, rank 0 highest. Reset: rank r = r.
  - 0x02 HOLD: `[TIMER_W-1:0]`, reset `HOLD_DEFAULT`.
  - 0x03 THRESH: `[ERR_W-1:0]`, reset all-ones.
  - 0x04 STATUS, read-only: [CH_W-1:0] mux_control, [8 +: N_CH] valid, [16] en_mux, [18:17] state.
  - 0x10+i ERR_i, read-only: zero-extended err_count of channel i.
- Unmapped or out-of-range reads return 0. Writes to read-only or unmapped addresses are ignored.
- Eligible(ch): `valid[ch] && err_count[ch] <= THRESH`, unsigned compare.
- best: channel at the lowest rank that is eligible. Duplicate ranks are harmless. Channels absent from PRIO are never auto-selected.
- FSM, encoded 0..2 in STATUS:
  - NO_SIG (0): `en_mux`=0, `mux_control` holds. manual_en → MANUAL. Otherwise, if best exists: select best, load timer=HOLD, → LOCKED.
  - LOCKED (1): `en_mux`=`valid[mux_control]`. manual_en → MANUAL (takes priority over all else). Timer decrements to 0 and saturates.
    - With fallback_en=1, current invalid: switch to best immediately, ignoring timer, and reload timer. If no best → NO_SIG.
    - With fallback_en=1, current valid but err > THRESH: switch only when timer==0 and best ≠ current. Reload timer on switch.
    - With fallback_en=0: never auto-switch. `en_mux` follows valid.
  - MANUAL (2): `mux_control`=manual_ch, `en_mux`=`valid[manual_ch]`, timer frozen. manual_en cleared → LOCKED on the current channel with timer reloaded.
- PRIO, THRESH or HOLD writes mid-operation affect the next decision only. They never force a switch by themselves, except through `MC_REVERT_EN`.

## Timing
- Reset values: `mux_control`=0, `en_mux`=0, `timer`=0, `mm_rdata`=0, state=NO_SIG.
- Register write is visible to FSM logic on the cycle after the `mm_write_en` edge.
- Read: `mm_rdata` valid on the edge after `mm_read_en`, held until the next read.
- Simultaneous read and write to the same address returns the old value.
- Decision latency: input change at edge k → `mux_control`/`en_mux`/state updated at edge k+1.
- Timer: loaded on the switch edge, decrements once per cycle. HOLD=0 means no holdoff.
- Reset asserted mid-operation returns everything to reset values asynchronously.

## Configuration
- `MC_REVERT_EN` defined:
  - In LOCKED with fallback_en=1 and timer==0, if a channel of higher rank than current is eligible, switch to it and reload timer.
  - Timer therefore also acts as the revert guard time.
- Undefined: no revert; the selection stays on the fallback channel until it faults.

## Structure
- `mc_pkg`: FSM state enum (NO_SIG/LOCKED/MANUAL), register address constants, CTRL bit positions, reset defaults.
- Sub-module `mc_prio_pick`: combinational rank scan producing best index, found flag and the rank of any channel. Used for both fallback and revert.

## Test plan
- Reset, PRIO ranks {2,0,1,3}, all valid, errors 0 → LOCKED, `mux_control`=2, `en_mux`=1, `timer`=30 then counting down.
- THRESH=10, err ch2=50 while timer=12 → no switch until timer=0, then `mux_control`=0, timer=30.
- Drop valid[2] while timer=25 → next edge `mux_control`=0, timer reloaded to 30.
- CTRL manual_en=1, manual_ch=3, valid[3]=0 → MANUAL, `mux_control`=3, `en_mux`=0. Clear manual_en → LOCKED on 3.
- All valid=0 → NO_SIG, `en_mux`=0. Read 0x04 → state field 0. Read 0x12 → err_count ch2 zero-extended, one cycle after the strobe.
- `MC_REVERT_EN`: on ch0 after fallback from ch2, ch2 recovers, timer=0 → `mux_control`=2. Without the macro, stays on 0.

Source files
------------

// File: rtl/mc_pkg.sv
// Shared types and constants for the channel selector: FSM states,
// register map, CTRL/STATUS field positions and reset defaults.
package mc_pkg;

  typedef enum logic [1:0] {
    ST_NO_SIG = 2'd0,
    ST_LOCKED = 2'd1,
    ST_MANUAL = 2'd2
  } mc_state_e;

  localparam logic [7:0] ADDR_CTRL     = 8'h00;
  localparam logic [7:0] ADDR_PRIO     = 8'h01;
  localparam logic [7:0] ADDR_HOLD     = 8'h02;
  localparam logic [7:0] ADDR_THRESH   = 8'h03;
  localparam logic [7:0] ADDR_STATUS   = 8'h04;
  localparam logic [7:0] ADDR_ERR_BASE = 8'h10;

  localparam int unsigned CTRL_FALLBACK_BIT = 0;
  localparam int unsigned CTRL_MANUAL_BIT   = 1;
  localparam int unsigned CTRL_MANCH_LSB    = 2;

  localparam int unsigned STAT_VALID_LSB = 8;
  localparam int unsigned STAT_EN_BIT    = 16;
  localparam int unsigned STAT_STATE_LSB = 17;

  localparam logic FALLBACK_RST = 1'b1;
  localparam logic MANUAL_RST   = 1'b0;

endpackage

// File: rtl/mc_prio_pick.sv
// Priority-list scan: lowest-rank eligible channel, plus the best rank
// of a queried channel so callers can compare current against best.
module mc_prio_pick #(
  parameter int unsigned N_CH = 4,
  parameter int unsigned CH_W = $clog2(N_CH)
) (
  input  logic [N_CH*CH_W-1:0] prio_i,
  input  logic [N_CH-1:0]      elig_i,
  input  logic [CH_W-1:0]      cur_i,
  output logic [CH_W-1:0]      best_o,
  output logic                 found_o,
  output logic [CH_W-1:0]      best_rank_o,
  output logic [CH_W-1:0]      cur_rank_o,
  output logic                 cur_ranked_o
);

  // Scan from the lowest priority upward so the highest-priority hit wins.
  always_comb begin
    best_o       = '0;
    found_o      = 1'b0;
    best_rank_o  = '0;
    cur_rank_o   = '0;
    cur_ranked_o = 1'b0;
    for (int r = N_CH - 1; r >= 0; r--) begin
      if (32'(prio_i[r*CH_W +: CH_W]) < N_CH && elig_i[prio_i[r*CH_W +: CH_W]]) begin
        best_o      = prio_i[r*CH_W +: CH_W];
        found_o     = 1'b1;
        best_rank_o = CH_W'(r);
      end
      if (prio_i[r*CH_W +: CH_W] == cur_i) begin
        cur_rank_o   = CH_W'(r);
        cur_ranked_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/mc_channel_select.sv
// Transport-stream channel selector with register port, fault threshold,
// holdoff timer and manual override. Define MC_REVERT_EN for auto-revert.
module mc_channel_select
  import mc_pkg::*;
#(
  parameter int unsigned N_CH         = 4,
  parameter int unsigned CH_W         = $clog2(N_CH),
  parameter int unsigned ERR_W        = 8,
  parameter int unsigned TIMER_W      = 20,
  parameter int unsigned HOLD_DEFAULT = 30
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [N_CH-1:0]       valid,
  input  logic [N_CH*ERR_W-1:0] err_count,
  input  logic                  mm_write_en,
  input  logic                  mm_read_en,
  input  logic [7:0]            mm_addr,
  input  logic [31:0]           mm_wdata,
  output logic [31:0]           mm_rdata,
  output logic [CH_W-1:0]       mux_control,
  output logic                  en_mux,
  output logic [TIMER_W-1:0]    timer
);

  function automatic logic [N_CH*CH_W-1:0] prio_init();
    logic [N_CH*CH_W-1:0] v;
    v = '0;
    for (int r = 0; r < N_CH; r++) v[r*CH_W +: CH_W] = CH_W'(r);
    return v;
  endfunction

  localparam logic [N_CH*CH_W-1:0] PRIO_RST = prio_init();

  logic                 fallback_q, manual_q;
  logic [CH_W-1:0]      manual_ch_q;
  logic [N_CH*CH_W-1:0] prio_q;
  logic [TIMER_W-1:0]   hold_q;
  logic [ERR_W-1:0]     thresh_q;
  logic [31:0]          rdata_q, rdata_c;
  mc_state_e            state_q, state_d;
  logic [CH_W-1:0]      mux_q, mux_d;
  logic                 en_q, en_d;
  logic [TIMER_W-1:0]   timer_q, timer_d, timer_dec_c;

  logic [ERR_W-1:0] err_arr_c [N_CH];
  logic [N_CH-1:0]  elig_c;
  logic             cur_valid_c, cur_fault_c, man_valid_c;
  logic [CH_W-1:0]  best_c, best_rank_c, cur_rank_c;
  logic             found_c, cur_ranked_c, best_differs_c, revert_c;
  logic             unused_ok_c;

  assign unused_ok_c = ^mm_wdata;

  // Per-channel eligibility and the status of the current/manual channels.
  always_comb begin
    cur_valid_c = 1'b0;
    cur_fault_c = 1'b0;
    man_valid_c = 1'b0;
    for (int ch = 0; ch < N_CH; ch++) begin
      err_arr_c[ch] = err_count[ch*ERR_W +: ERR_W];
      elig_c[ch]    = valid[ch] && (err_arr_c[ch] <= thresh_q);
      if (CH_W'(ch) == mux_q) begin
        cur_valid_c = valid[ch];
        cur_fault_c = err_arr_c[ch] > thresh_q;
      end
      if (CH_W'(ch) == manual_ch_q) man_valid_c = valid[ch];
    end
  end

  mc_prio_pick #(.N_CH(N_CH), .CH_W(CH_W)) u_pick (
    .prio_i      (prio_q),
    .elig_i      (elig_c),
    .cur_i       (mux_q),
    .best_o      (best_c),
    .found_o     (found_c),
    .best_rank_o (best_rank_c),
    .cur_rank_o  (cur_rank_c),
    .cur_ranked_o(cur_ranked_c)
  );

  // Same rank means same channel, so the rank compare doubles as best != current.
  assign best_differs_c = found_c && (!cur_ranked_c || best_rank_c != cur_rank_c);
`ifdef MC_REVERT_EN
  assign revert_c = found_c && (!cur_ranked_c || best_rank_c < cur_rank_c);
`else
  assign revert_c = 1'b0;
`endif
  assign timer_dec_c = (timer_q == '0) ? '0 : timer_q - TIMER_W'(1);

  always_comb begin
    state_d = state_q;
    mux_d   = mux_q;
    en_d    = en_q;
    timer_d = timer_q;
    case (state_q)
      ST_NO_SIG: begin
        en_d = 1'b0;
        if (manual_q) begin
          state_d = ST_MANUAL;
          mux_d   = manual_ch_q;
          en_d    = man_valid_c;
        end else if (found_c) begin
          state_d = ST_LOCKED;
          mux_d   = best_c;
          en_d    = 1'b1;
          timer_d = hold_q;
        end
      end
      ST_LOCKED: begin
        if (manual_q) begin
          state_d = ST_MANUAL;
          mux_d   = manual_ch_q;
          en_d    = man_valid_c;
        end else begin
          timer_d = timer_dec_c;
          en_d    = cur_valid_c;
          if (fallback_q) begin
            if (!cur_valid_c) begin
              if (found_c) begin
                mux_d   = best_c;
                en_d    = 1'b1;
                timer_d = hold_q;
              end else begin
                state_d = ST_NO_SIG;
                en_d    = 1'b0;
              end
            end else if (timer_q == '0 && best_differs_c && (cur_fault_c || revert_c)) begin
              mux_d   = best_c;
              en_d    = 1'b1;
              timer_d = hold_q;
            end
          end
        end
      end
      ST_MANUAL: begin
        mux_d = manual_ch_q;
        en_d  = man_valid_c;
        if (!manual_q) begin
          state_d = ST_LOCKED;
          mux_d   = mux_q;
          en_d    = cur_valid_c;
          timer_d = hold_q;
        end
      end
      default: state_d = ST_NO_SIG;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= ST_NO_SIG;
      mux_q   <= '0;
      en_q    <= 1'b0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      mux_q   <= mux_d;
      en_q    <= en_d;
      timer_q <= timer_d;
    end
  end

  // Configuration registers; read-only and unmapped addresses drop writes.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fallback_q  <= FALLBACK_RST;
      manual_q    <= MANUAL_RST;
      manual_ch_q <= '0;
      prio_q      <= PRIO_RST;
      hold_q      <= TIMER_W'(HOLD_DEFAULT);
      thresh_q    <= '1;
    end else if (mm_write_en) begin
      case (mm_addr)
        ADDR_CTRL: begin
          fallback_q  <= mm_wdata[CTRL_FALLBACK_BIT];
          manual_q    <= mm_wdata[CTRL_MANUAL_BIT];
          manual_ch_q <= mm_wdata[CTRL_MANCH_LSB +: CH_W];
        end
        ADDR_PRIO:   prio_q   <= mm_wdata[N_CH*CH_W-1:0];
        ADDR_HOLD:   hold_q   <= mm_wdata[TIMER_W-1:0];
        ADDR_THRESH: thresh_q <= mm_wdata[ERR_W-1:0];
        default: ;
      endcase
    end
  end

  always_comb begin
    rdata_c = '0;
    case (mm_addr)
      ADDR_CTRL: begin
        rdata_c[CTRL_FALLBACK_BIT]        = fallback_q;
        rdata_c[CTRL_MANUAL_BIT]          = manual_q;
        rdata_c[CTRL_MANCH_LSB +: CH_W]   = manual_ch_q;
      end
      ADDR_PRIO:   rdata_c[N_CH*CH_W-1:0] = prio_q;
      ADDR_HOLD:   rdata_c[TIMER_W-1:0]   = hold_q;
      ADDR_THRESH: rdata_c[ERR_W-1:0]     = thresh_q;
      ADDR_STATUS: begin
        rdata_c[CH_W-1:0]              = mux_q;
        rdata_c[STAT_VALID_LSB +: N_CH] = valid;
        rdata_c[STAT_EN_BIT]           = en_q;
        rdata_c[STAT_STATE_LSB +: 2]   = state_q;
      end
      default: begin
        for (int ch = 0; ch < N_CH; ch++)
          if (mm_addr == ADDR_ERR_BASE + 8'(ch)) rdata_c[ERR_W-1:0] = err_arr_c[ch];
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst)            rdata_q <= '0;
    else if (mm_read_en) rdata_q <= rdata_c;
  end

  assign mm_rdata    = rdata_q;
  assign mux_control = mux_q;
  assign en_mux      = en_q;
  assign timer       = timer_q;

endmodule

// File: tb/tb_mc_channel_select.sv
// Scoreboard bench for mc_channel_select: each cycle queues the expected
// mux/enable/timer (and read data) and compares them after the edge.
module tb_mc_channel_select;
  import mc_pkg::*;

  localparam int unsigned N_CH = 4;
  localparam int unsigned CH_W = 2;
  localparam int unsigned ERR_W = 8;
  localparam int unsigned TIMER_W = 20;

  logic                  clk = 1'b0;
  logic                  rst;
  logic [N_CH-1:0]       valid;
  logic [N_CH*ERR_W-1:0] err_count;
  logic                  mm_write_en, mm_read_en;
  logic [7:0]            mm_addr;
  logic [31:0]           mm_wdata, mm_rdata;
  logic [CH_W-1:0]       mux_control;
  logic                  en_mux;
  logic [TIMER_W-1:0]    timer;

  mc_channel_select #(
    .N_CH(N_CH), .ERR_W(ERR_W), .TIMER_W(TIMER_W), .HOLD_DEFAULT(30)
  ) dut (
    .clk(clk), .rst(rst), .valid(valid), .err_count(err_count),
    .mm_write_en(mm_write_en), .mm_read_en(mm_read_en), .mm_addr(mm_addr),
    .mm_wdata(mm_wdata), .mm_rdata(mm_rdata), .mux_control(mux_control),
    .en_mux(en_mux), .timer(timer)
  );

  always #5 clk = ~clk;

  typedef struct {
    string       tag;
    int unsigned kind;
    logic [31:0] exp;
  } sb_t;

  sb_t                sb_q[$];
  int                 n_vec = 0;
  int                 n_err = 0;
  logic [CH_W-1:0]    e_mux;
  logic               e_en;
  logic [TIMER_W-1:0] e_tmr;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, act, exp);
    end
  endtask

  task automatic push(input string tag, input int unsigned kind, input logic [31:0] exp);
    sb_t e;
    e.tag  = tag;
    e.kind = kind;
    e.exp  = exp;
    sb_q.push_back(e);
  endtask

  task automatic push_outs(input string tag);
    push({tag, ".mux"}, 0, 32'(e_mux));
    push({tag, ".en"}, 1, 32'(e_en));
    push({tag, ".timer"}, 2, 32'(e_tmr));
  endtask

  task automatic drain();
    sb_t e;
    while (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      case (e.kind)
        0:       check(e.tag, 32'(mux_control), e.exp);
        1:       check(e.tag, 32'(en_mux), e.exp);
        2:       check(e.tag, 32'(timer), e.exp);
        default: check(e.tag, mm_rdata, e.exp);
      endcase
    end
  endtask

  // One clock: optionally age the expected timer, queue expectations, compare.
  task automatic tick(input bit dec, input string tag);
    if (dec && e_tmr != '0) e_tmr = e_tmr - 1'b1;
    push_outs(tag);
    @(posedge clk);
    #1;
    drain();
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d, input bit dec, input string tag);
    mm_write_en = 1'b1;
    mm_addr     = a;
    mm_wdata    = d;
    tick(dec, tag);
    mm_write_en = 1'b0;
  endtask

  task automatic rd(input logic [7:0] a, input logic [31:0] exp, input bit dec, input string tag);
    mm_read_en = 1'b1;
    mm_addr    = a;
    push({tag, ".rdata"}, 3, exp);
    tick(dec, tag);
    mm_read_en = 1'b0;
  endtask

  task automatic set_err(input int ch, input logic [ERR_W-1:0] v);
    err_count[ch*ERR_W +: ERR_W] = v;
  endtask

  initial begin
    rst = 1'b1;
    valid = '0;
    err_count = '0;
    mm_write_en = 1'b0;
    mm_read_en = 1'b0;
    mm_addr = '0;
    mm_wdata = '0;
    e_mux = '0;
    e_en = 1'b0;
    e_tmr = '0;
    #1 rst = 1'b0;
    #1;
    push_outs("reset");
    push("reset.rdata", 3, 32'h0);
    drain();
    @(negedge clk);
    rst = 1'b1;

    // Ranks {2,0,1,3}; no signal yet, so nothing locks.
    wr(ADDR_PRIO, 32'h0000_00D2, 0, "prio_wr");
    valid = 4'hF;
    e_mux = 2'd2; e_en = 1'b1; e_tmr = 20'd30;
    tick(0, "lock");
    rd(ADDR_STATUS, 32'h0003_0F02, 1, "stat_locked");
    while (e_tmr != 20'd25) tick(1, "hold_cnt");

    // Current channel loses signal: immediate fallback to rank 1.
    valid = 4'b1011;
    e_mux = 2'd0; e_tmr = 20'd30;
    tick(0, "drop2");
    valid = 4'hF;
    while (e_tmr != '0) tick(1, "on0");
`ifdef MC_REVERT_EN
    e_mux = 2'd2; e_tmr = 20'd30;
    tick(0, "revert");
`else
    tick(1, "no_revert");
`endif

    // Manual override onto a channel without signal, then release.
    valid = 4'b0111;
    wr(ADDR_CTRL, 32'h0000_000F, 1, "man_wr");
    e_mux = 2'd3; e_en = 1'b0;
    tick(0, "manual");
    tick(0, "manual_hold");
    wr(ADDR_CTRL, 32'h0000_000D, 0, "man_clr_wr");
    e_tmr = 20'd30;
    tick(0, "man_exit");
    e_mux = 2'd2; e_en = 1'b1; e_tmr = 20'd30;
    tick(0, "fb_from3");

    // Error threshold fault waits for the holdoff to expire.
    wr(ADDR_THRESH, 32'd10, 1, "thr_wr");
    while (e_tmr != 20'd12) tick(1, "pre_err");
    set_err(2, 8'd50);
    while (e_tmr != '0) tick(1, "err_hold");
    e_mux = 2'd0; e_tmr = 20'd30;
    tick(0, "err_switch");
    repeat (3) tick(1, "on0_b");

    // All signals gone.
    valid = '0;
    e_en = 1'b0;
    tick(1, "nosig");
    set_err(3, 8'hA5);
    rd(ADDR_STATUS, 32'h0, 0, "stat_nosig");
    rd(8'h12, 32'h0000_0032, 0, "err2");
    rd(8'h13, 32'h0000_00A5, 0, "err3");
    rd(8'h14, 32'h0, 0, "err_oor");
    rd(8'h05, 32'h0, 0, "unmapped");
    rd(ADDR_PRIO, 32'h0000_00D2, 0, "prio_rd");
    rd(ADDR_CTRL, 32'h0000_000D, 0, "ctrl_rd");
    rd(ADDR_THRESH, 32'h0000_000A, 0, "thr_rd");
    mm_write_en = 1'b1;
    mm_wdata = 32'd5;
    rd(ADDR_HOLD, 32'd30, 0, "hold_rdwr");
    mm_write_en = 1'b0;
    rd(ADDR_HOLD, 32'd5, 0, "hold_rd");
    wr(ADDR_STATUS, 32'hFFFF_FFFF, 0, "ro_wr");
    rd(ADDR_STATUS, 32'h0, 0, "stat_ro");

    // Relock from NO_SIG uses the new holdoff value.
    valid = 4'b0010;
    e_mux = 2'd1; e_en = 1'b1; e_tmr = 20'd5;
    tick(0, "relock");
    tick(1, "relock_cnt");

    // Asynchronous reset mid-cycle.
    #3 rst = 1'b0;
    #1;
    e_mux = '0; e_en = 1'b0; e_tmr = '0;
    push_outs("mid_reset");
    push("mid_reset.rdata", 3, 32'h0);
    drain();
    rst = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
